// File: rtl/shift_register_unit_if.sv
// shift_register_unit_if: control, data and status bundle of the shift register unit
interface shift_register_unit_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             clr;
  logic             set;
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] d_in;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;
  modport master (
    output clr, set, start, op, amt, d_in, ser_in,
    input  q, ser_out, busy, done
  );
  modport slave (
    input  clr, set, start, op, amt, d_in, ser_in,
    output q, ser_out, busy, done
  );
endinterface

// File: rtl/shift_register_unit.sv
// shift_register_unit: WIDTH-bit register with sync clear/set, parallel load and one-bit-per-cycle shifts/rotates
module shift_register_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic clk,
  input logic rst,
  shift_register_unit_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_SAR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_ROR = 3'b110;
  logic [0:0]       r_state;
  logic [2:0]       r_op;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_ser;
  logic             r_done;
  logic [WIDTH-1:0] w_nxt;
  logic             w_out;
  logic             w_is_shift;
  // r_op only ever holds a shift code, so ROR is the fall-through case
  always_comb begin
    w_nxt = r_op == OP_SHL ? {r_q[WIDTH-2:0], bus.ser_in} :
            r_op == OP_SHR ? {bus.ser_in, r_q[WIDTH-1:1]} :
            r_op == OP_SAR ? {r_q[WIDTH-1], r_q[WIDTH-1:1]} :
            r_op == OP_ROL ? {r_q[WIDTH-2:0], r_q[WIDTH-1]} :
                             {r_q[0], r_q[WIDTH-1:1]};
    w_out = (r_op == OP_SHL || r_op == OP_ROL) ? r_q[WIDTH-1] : r_q[0];
  end
  assign w_is_shift  = bus.op >= OP_SHL && bus.op <= OP_ROR;
  assign bus.q       = r_q;
  assign bus.ser_out = r_ser;
  assign bus.busy    = r_state == SHIFT;
  assign bus.done    = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_ser   <= 1'b0;
      r_done  <= 1'b0;
    end else if (!bus.clr) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else if (!bus.set) begin
      r_state <= IDLE;
      r_q     <= '1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start) begin
          if (bus.op == OP_LOAD) begin
            r_q    <= bus.d_in;
            r_done <= 1'b1;
          end else if (w_is_shift && |bus.amt) begin
            r_op    <= bus.op;
            r_cnt   <= bus.amt;
            r_state <= SHIFT;
          end else begin
            r_done <= 1'b1;
          end
        end
      end else begin
        r_q   <= w_nxt;
        r_ser <= w_out;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == AMT_W'(1)) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_register_unit.sv
// tb_shift_register_unit: directed vector table plus hand-written abort and handshake sequences
module tb_shift_register_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  shift_register_unit_if #(.WIDTH(8), .AMT_W(4)) bus ();
  shift_register_unit #(.WIDTH(8), .AMT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] d;
    logic       ser;
    logic [7:0] q;
    logic       so;
    logic       chk_so;
    int         cyc;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic kick_now(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] d, input logic ser);
    bus.op = op;
    bus.amt = amt;
    bus.d_in = d;
    bus.ser_in = ser;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic kick(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] d, input logic ser);
    @(negedge clk);
    kick_now(op, amt, d, ser);
  endtask
  task automatic wait_done(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        got = 1'b1;
        chk("done_with_busy", {31'b0, bus.busy}, 0);
        break;
      end
      if (bus.busy) cyc++;
      @(negedge clk);
    end
  endtask
  task automatic load(input logic [7:0] d);
    int c;
    bit g;
    kick(3'b001, 4'd0, d, 1'b0);
    wait_done(c, g);
    chk("load_done", {31'b0, g}, 1);
    chk("load_q", {24'b0, bus.q}, {24'b0, d});
  endtask
  initial begin
    int c;
    int n;
    bit g;
    v[0]  = '{3'b101, 4'd3,  8'hB5, 1'b0, 8'hAD, 1'b1, 1'b1, 3};
    v[1]  = '{3'b100, 4'd2,  8'h90, 1'b0, 8'hE4, 1'b0, 1'b1, 2};
    v[2]  = '{3'b011, 4'd2,  8'h90, 1'b0, 8'h24, 1'b0, 1'b1, 2};
    v[3]  = '{3'b010, 4'd10, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 10};
    v[4]  = '{3'b010, 4'd10, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 10};
    v[5]  = '{3'b010, 4'd0,  8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 0};
    v[6]  = '{3'b110, 4'd1,  8'h01, 1'b0, 8'h80, 1'b1, 1'b1, 1};
    v[7]  = '{3'b100, 4'd9,  8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 9};
    v[8]  = '{3'b000, 4'd5,  8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0, 0};
    v[9]  = '{3'b111, 4'd3,  8'hC3, 1'b1, 8'hC3, 1'b0, 1'b0, 0};
    v[10] = '{3'b010, 4'd3,  8'h81, 1'b1, 8'h0F, 1'b0, 1'b1, 3};
    v[11] = '{3'b110, 4'd15, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1, 15};
    v[12] = '{3'b011, 4'd4,  8'h0F, 1'b1, 8'hF0, 1'b1, 1'b1, 4};
    for (int i = 0; i < 2; i++) begin
      bus.clr = 1'($urandom);
      bus.set = 1'($urandom);
      bus.start = 1'($urandom);
      bus.op = 3'($urandom);
      bus.amt = 4'($urandom);
      bus.d_in = 8'($urandom);
      bus.ser_in = 1'($urandom);
      @(negedge clk);
    end
    chk("rst_q", {24'b0, bus.q}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_ser_out", {31'b0, bus.ser_out}, 0);
    rst = 1'b0;
    bus.clr = 1'b1;
    bus.set = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      load(v[i].d);
      kick(v[i].op, v[i].amt, v[i].d, v[i].ser);
      wait_done(c, g);
      chk($sformatf("v%0d_done", i), {31'b0, g}, 1);
      chk($sformatf("v%0d_q", i), {24'b0, bus.q}, {24'b0, v[i].q});
      chk($sformatf("v%0d_busy_cycles", i), c, v[i].cyc);
      if (v[i].chk_so) chk($sformatf("v%0d_ser_out", i), {31'b0, bus.ser_out}, {31'b0, v[i].so});
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", i), {31'b0, bus.done}, 0);
    end
    // ROL step by step
    load(8'hB5);
    kick(3'b101, 4'd3, 8'h00, 1'b0);
    chk("rol_q0", {24'b0, bus.q}, 32'hB5);
    @(negedge clk);
    chk("rol_q1", {24'b0, bus.q}, 32'h6B);
    @(negedge clk);
    chk("rol_q2", {24'b0, bus.q}, 32'hD6);
    chk("rol_busy2", {31'b0, bus.busy}, 1);
    @(negedge clk);
    chk("rol_q3", {24'b0, bus.q}, 32'hAD);
    chk("rol_done3", {31'b0, bus.done}, 1);
    // clr+set abort at 2nd shift edge
    load(8'hB5);
    kick(3'b101, 4'd5, 8'h00, 1'b0);
    @(negedge clk);
    bus.clr = 1'b0;
    bus.set = 1'b0;
    @(negedge clk);
    chk("clr_q", {24'b0, bus.q}, 0);
    chk("clr_busy", {31'b0, bus.busy}, 0);
    chk("clr_ser_out_held", {31'b0, bus.ser_out}, 1);
    bus.clr = 1'b1;
    bus.set = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) n++;
      @(negedge clk);
    end
    chk("clr_no_done", n, 0);
    chk("clr_q_after", {24'b0, bus.q}, 0);
    // set abort, then start in the very next cycle
    load(8'hB5);
    kick(3'b101, 4'd5, 8'h00, 1'b0);
    @(negedge clk);
    bus.set = 1'b0;
    @(negedge clk);
    chk("set_q", {24'b0, bus.q}, 32'hFF);
    chk("set_busy", {31'b0, bus.busy}, 0);
    chk("set_done", {31'b0, bus.done}, 0);
    bus.set = 1'b1;
    kick_now(3'b001, 4'd0, 8'h42, 1'b0);
    wait_done(c, g);
    chk("after_set_done", {31'b0, g}, 1);
    chk("after_set_q", {24'b0, bus.q}, 32'h42);
    // rst beats clr/set mid-shift
    load(8'hB5);
    kick(3'b101, 4'd5, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.clr = 1'b0;
    bus.set = 1'b0;
    @(negedge clk);
    chk("rst_mid_q", {24'b0, bus.q}, 0);
    chk("rst_mid_ser_out", {31'b0, bus.ser_out}, 0);
    chk("rst_mid_busy", {31'b0, bus.busy}, 0);
    rst = 1'b0;
    bus.clr = 1'b1;
    bus.set = 1'b1;
    // start during busy is ignored
    load(8'h01);
    kick(3'b101, 4'd4, 8'h00, 1'b0);
    bus.op = 3'b001;
    bus.d_in = 8'h33;
    bus.amt = 4'd1;
    bus.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("busy_ign_busy", {31'b0, bus.busy}, 1);
    chk("busy_ign_q", {24'b0, bus.q}, 32'h04);
    bus.start = 1'b0;
    wait_done(c, g);
    chk("busy_ign_done", {31'b0, g}, 1);
    chk("busy_ign_final_q", {24'b0, bus.q}, 32'h10);
    // back-to-back: start in the done cycle
    load(8'h0F);
    kick(3'b010, 4'd1, 8'h00, 1'b0);
    wait_done(c, g);
    chk("b2b_first_q", {24'b0, bus.q}, 32'h1E);
    kick_now(3'b110, 4'd2, 8'h00, 1'b0);
    wait_done(c, g);
    chk("b2b_done", {31'b0, g}, 1);
    chk("b2b_cycles", c, 2);
    chk("b2b_q", {24'b0, bus.q}, 32'h87);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
